// File: rtl/data_word_assembler.sv
// data_word_assembler: packs synchronized beats into words behind a one-word valid/ready holding stage
module data_word_assembler #(
  parameter int BUS_WIDTH = 4,
  parameter int BEATS_PER_WORD = 2,
  localparam int WORD_WIDTH = BUS_WIDTH * BEATS_PER_WORD,
  localparam int CNT_WIDTH = $clog2(BEATS_PER_WORD + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BUS_WIDTH-1:0]  in_data,
  input  logic                  in_valid,
  input  logic                  flush,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_word,
  output logic                  out_valid,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic                  overflow,
  output logic                  partial_dropped
);
  typedef enum logic {S_COLLECT, S_HOLD} state_t;
  localparam logic [WORD_WIDTH-1:0] BEAT_MASK = WORD_WIDTH'({BUS_WIDTH{1'b1}});
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(BEATS_PER_WORD - 1);
  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(BEATS_PER_WORD);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  state_t                r_state, w_state_nxt;
  logic [WORD_WIDTH-1:0] r_asm, w_asm_nxt, r_out, w_out_nxt, w_asm_ins;
  logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_nxt;
  logic                  r_valid, w_valid_nxt, r_ovf, w_ovf_nxt, r_pd, w_pd_nxt;
  logic                  w_slot_free;
  assign w_slot_free = !r_valid || out_ready;
  assign w_asm_ins = (r_asm & ~(BEAT_MASK << (r_cnt * BUS_WIDTH))) | (WORD_WIDTH'(in_data) << (r_cnt * BUS_WIDTH));
  assign out_word = r_out;
  assign out_valid = r_valid;
  assign beat_count = r_cnt;
  assign overflow = r_ovf;
  assign partial_dropped = r_pd;
  // Next-state: a completed word in HOLD has priority over flush; flush beats a coincident beat in COLLECT
  always_comb begin
    w_state_nxt = r_state;
    w_asm_nxt = r_asm;
    w_cnt_nxt = r_cnt;
    w_out_nxt = r_out;
    w_valid_nxt = r_valid && !out_ready;
    w_ovf_nxt = 1'b0;
    w_pd_nxt = 1'b0;
    if (r_state == S_HOLD) begin
      if (w_slot_free) begin
        w_out_nxt = r_asm;
        w_valid_nxt = 1'b1;
        w_state_nxt = S_COLLECT;
        w_asm_nxt = in_valid ? WORD_WIDTH'(in_data) : '0;
        w_cnt_nxt = in_valid ? ONE : '0;
      end else begin
        w_ovf_nxt = in_valid;
      end
    end else if (flush) begin
      w_asm_nxt = '0;
      w_cnt_nxt = '0;
      w_pd_nxt = (|r_cnt) || in_valid;
    end else if (in_valid) begin
      w_asm_nxt = w_asm_ins;
      if (r_cnt != LAST) begin
        w_cnt_nxt = r_cnt + ONE;
      end else if (w_slot_free) begin
        w_out_nxt = w_asm_ins;
        w_valid_nxt = 1'b1;
        w_cnt_nxt = '0;
        w_asm_nxt = '0;
      end else begin
        w_cnt_nxt = FULL;
        w_state_nxt = S_HOLD;
      end
    end
  end
  // State and output registers, cleared immediately by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_COLLECT;
      r_asm <= '0;
      r_cnt <= '0;
      r_out <= '0;
      r_valid <= 1'b0;
      r_ovf <= 1'b0;
      r_pd <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_asm <= w_asm_nxt;
      r_cnt <= w_cnt_nxt;
      r_out <= w_out_nxt;
      r_valid <= w_valid_nxt;
      r_ovf <= w_ovf_nxt;
      r_pd <= w_pd_nxt;
    end
  end
endmodule
